// File: rtl/tl_traffic_gen.sv
// tl_traffic_gen: TileLink-UL traffic generator and response checker.
// Host commands queue in a FIFO, issue on A with up to MAX_INFLIGHT sources outstanding, and are scored on D.

module tl_tg_slot #(
  parameter int DATA_BYTES = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_load,
  input  logic                    i_is_get,
  input  logic [8*DATA_BYTES-1:0] i_exp,
  input  logic [DATA_BYTES-1:0]   i_mask,
  input  logic                    i_set,
  input  logic                    i_clr,
  input  logic [2:0]              i_d_opcode,
  input  logic [8*DATA_BYTES-1:0] i_d_data,
  input  logic                    i_d_denied,
  input  logic                    i_d_corrupt,
  output logic                    o_busy,
  output logic                    o_fail
);
  logic                    r_busy, r_is_get;
  logic [8*DATA_BYTES-1:0] r_exp, w_bmask;
  logic [DATA_BYTES-1:0]   r_mask;
  logic                    w_op_bad, w_data_bad;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy   <= 1'b0;
      r_is_get <= 1'b0;
      r_exp    <= '0;
      r_mask   <= '0;
    end else begin
      if (i_set)      r_busy <= 1'b1;
      else if (i_clr) r_busy <= 1'b0;
      if (i_load) begin
        r_is_get <= i_is_get;
        r_exp    <= i_exp;
        r_mask   <= i_mask;
      end
    end
  end

  for (genvar b = 0; b < DATA_BYTES; b++) begin : g_bexp
    assign w_bmask[8*b +: 8] = {8{r_mask[b]}};
  end

  // GET expects AccessAckData (1), PUTs expect AccessAck (0)
  assign w_op_bad   = i_d_opcode != {2'b00, r_is_get};
  assign w_data_bad = r_is_get && (((i_d_data ^ r_exp) & w_bmask) != '0);
  assign o_fail     = i_d_denied | i_d_corrupt | w_op_bad | w_data_bad;
  assign o_busy     = r_busy;
endmodule

module tl_traffic_gen #(
  parameter int ADDR_BITS    = 32,
  parameter int DATA_BYTES   = 8,
  parameter int SIZE_BITS    = 3,
  parameter int SOURCE_BITS  = 4,
  parameter int MAX_INFLIGHT = 4,
  parameter int CMD_DEPTH    = 8,
  parameter int CNT_BITS     = 16,
  parameter int TIMEOUT      = 1024
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_cmd_valid,
  output logic                              o_cmd_ready,
  input  logic [1:0]                        i_cmd_type,
  input  logic [ADDR_BITS-1:0]              i_cmd_addr,
  input  logic [SIZE_BITS-1:0]              i_cmd_size,
  input  logic [8*DATA_BYTES-1:0]           i_cmd_data,
  input  logic [DATA_BYTES-1:0]             i_cmd_mask,
  input  logic                              i_enable,
  output logic                              o_a_valid,
  input  logic                              i_a_ready,
  output logic [2:0]                        o_a_opcode,
  output logic [2:0]                        o_a_param,
  output logic [SIZE_BITS-1:0]              o_a_size,
  output logic [SOURCE_BITS-1:0]            o_a_source,
  output logic [ADDR_BITS-1:0]              o_a_address,
  output logic [DATA_BYTES-1:0]             o_a_mask,
  output logic [8*DATA_BYTES-1:0]           o_a_data,
  input  logic                              i_d_valid,
  output logic                              o_d_ready,
  input  logic [2:0]                        i_d_opcode,
  input  logic [SOURCE_BITS-1:0]            i_d_source,
  input  logic [8*DATA_BYTES-1:0]           i_d_data,
  input  logic                              i_d_denied,
  input  logic                              i_d_corrupt,
  output logic [CNT_BITS-1:0]               o_pass_count,
  output logic [CNT_BITS-1:0]               o_fail_count,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] o_inflight,
  output logic                              o_done,
  output logic                              o_err_unexp,
  output logic                              o_err_timeout,
  output logic [SOURCE_BITS-1:0]            o_first_fail_src
);
  localparam int IW = $clog2(MAX_INFLIGHT+1);
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int WW = $clog2(TIMEOUT+1);
  localparam int DW = 8*DATA_BYTES;

  typedef struct packed {
    logic [1:0]            typ;
    logic [ADDR_BITS-1:0]  addr;
    logic [SIZE_BITS-1:0]  size;
    logic [DW-1:0]         data;
    logic [DATA_BYTES-1:0] mask;
  } cmd_t;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  cmd_t                    r_fifo [CMD_DEPTH];
  logic [PW:0]             r_wp, r_rp;
  cmd_t                    w_head, w_cmd_in;
  logic                    w_empty, w_full, w_push, w_pop, w_drop, w_load, w_a_hs;
  state_t                  r_state, w_state_nxt;

  logic [2:0]              r_a_opcode;
  logic [SIZE_BITS-1:0]    r_a_size;
  logic [SOURCE_BITS-1:0]  r_a_source;
  logic [ADDR_BITS-1:0]    r_a_address;
  logic [DATA_BYTES-1:0]   r_a_mask;
  logic [DW-1:0]           r_a_data;

  logic [MAX_INFLIGHT-1:0] w_busy, w_sfail, w_load_sel, w_set_sel, w_dsel;
  logic                    w_any_free, w_d_hit, w_d_fail;
  logic [SOURCE_BITS-1:0]  w_free_idx;
  logic [IW-1:0]           w_inflight;
  logic [1:0]              w_pass_inc, w_fail_inc;

  logic [CNT_BITS-1:0]     r_pass, r_fail;
  logic                    r_ff_vld, r_err_unexp, r_err_to, r_done;
  logic [SOURCE_BITS-1:0]  r_ff_src;
  logic [WW-1:0]           r_wd;

  assign w_cmd_in = '{typ: i_cmd_type, addr: i_cmd_addr, size: i_cmd_size,
                      data: i_cmd_data, mask: i_cmd_mask};
  assign w_head   = r_fifo[r_rp[PW-1:0]];
  assign w_empty  = r_wp == r_rp;
  assign w_full   = (r_wp[PW] != r_rp[PW]) && (r_wp[PW-1:0] == r_rp[PW-1:0]);
  assign w_push   = i_cmd_valid && !w_full;
  assign w_drop   = w_pop && (w_head.typ == 2'd3);
  assign w_load   = w_pop && (w_head.typ != 2'd3);
  assign w_a_hs   = (r_state == S_ISSUE) && i_a_ready;

  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wp[PW-1:0]] <= w_cmd_in;
  end

  always_comb begin
    w_any_free = 1'b0;
    w_free_idx = '0;
    for (int i = MAX_INFLIGHT-1; i >= 0; i--)
      if (!w_busy[i]) begin
        w_any_free = 1'b1;
        w_free_idx = SOURCE_BITS'(i);
      end
  end

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < MAX_INFLIGHT; i++) w_inflight = w_inflight + IW'(w_busy[i]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Reserved type 3 is consumed in IDLE without leaving it, so it never takes a slot
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE:
        if (i_enable && !w_empty && w_any_free) begin
          w_pop = 1'b1;
          if (w_head.typ != 2'd3) w_state_nxt = S_ISSUE;
        end
      S_ISSUE:
        if (i_a_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  for (genvar s = 0; s < MAX_INFLIGHT; s++) begin : g_slot
    assign w_dsel[s]     = i_d_valid && (i_d_source == SOURCE_BITS'(s));
    assign w_load_sel[s] = w_load && (w_free_idx == SOURCE_BITS'(s));
    assign w_set_sel[s]  = w_a_hs && (r_a_source == SOURCE_BITS'(s));
    tl_tg_slot #(.DATA_BYTES(DATA_BYTES)) u_slot (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_load_sel[s]),
      .i_is_get   (w_head.typ == 2'd0),
      .i_exp      (w_head.data),
      .i_mask     (w_head.mask),
      .i_set      (w_set_sel[s]),
      .i_clr      (w_dsel[s]),
      .i_d_opcode (i_d_opcode),
      .i_d_data   (i_d_data),
      .i_d_denied (i_d_denied),
      .i_d_corrupt(i_d_corrupt),
      .o_busy     (w_busy[s]),
      .o_fail     (w_sfail[s])
    );
  end

  assign w_d_hit    = |(w_dsel & w_busy);
  assign w_d_fail   = |(w_dsel & w_busy & w_sfail);
  assign w_pass_inc = {1'b0, w_d_hit & ~w_d_fail};
  assign w_fail_inc = {1'b0, w_d_hit & w_d_fail} + {1'b0, w_drop};

  function automatic logic [CNT_BITS-1:0] sat_add(input logic [CNT_BITS-1:0] a,
                                                  input logic [1:0] inc);
    logic [CNT_BITS:0] s;
    s = {1'b0, a} + {{(CNT_BITS-1){1'b0}}, inc};
    return s[CNT_BITS] ? '1 : s[CNT_BITS-1:0];
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_a_opcode  <= '0;
      r_a_size    <= '0;
      r_a_source  <= '0;
      r_a_address <= '0;
      r_a_mask    <= '0;
      r_a_data    <= '0;
      r_pass      <= '0;
      r_fail      <= '0;
      r_ff_vld    <= 1'b0;
      r_ff_src    <= '0;
      r_err_unexp <= 1'b0;
      r_err_to    <= 1'b0;
      r_wd        <= '0;
      r_done      <= 1'b1;
    end else begin
      if (w_push) r_wp <= r_wp + (PW+1)'(1);
      if (w_pop)  r_rp <= r_rp + (PW+1)'(1);
      if (w_load) begin
        r_a_size    <= w_head.size;
        r_a_source  <= w_free_idx;
        r_a_address <= w_head.addr;
        case (w_head.typ)
          2'd0: begin r_a_opcode <= 3'd4; r_a_mask <= w_head.mask; r_a_data <= '0;          end
          2'd1: begin r_a_opcode <= 3'd0; r_a_mask <= '1;          r_a_data <= w_head.data; end
          default: begin r_a_opcode <= 3'd1; r_a_mask <= w_head.mask; r_a_data <= w_head.data; end
        endcase
      end
      r_pass <= sat_add(r_pass, w_pass_inc);
      r_fail <= sat_add(r_fail, w_fail_inc);
      if (w_d_hit && w_d_fail && !r_ff_vld) begin
        r_ff_vld <= 1'b1;
        r_ff_src <= i_d_source;
      end
      if (i_d_valid && !w_d_hit) r_err_unexp <= 1'b1;
      if (i_d_valid || (w_inflight == '0)) r_wd <= '0;
      else if (r_wd != WW'(TIMEOUT))       r_wd <= r_wd + WW'(1);
      if (r_wd == WW'(TIMEOUT)) r_err_to <= 1'b1;
      r_done <= w_empty && (w_inflight == '0) && (r_state == S_IDLE);
    end
  end

  assign o_cmd_ready      = !w_full;
  assign o_a_valid        = r_state == S_ISSUE;
  assign o_a_opcode       = r_a_opcode;
  assign o_a_param        = 3'd0;
  assign o_a_size         = r_a_size;
  assign o_a_source       = r_a_source;
  assign o_a_address      = r_a_address;
  assign o_a_mask         = r_a_mask;
  assign o_a_data         = r_a_data;
  assign o_d_ready        = 1'b1;
  assign o_pass_count     = r_pass;
  assign o_fail_count     = r_fail;
  assign o_inflight       = w_inflight;
  assign o_done           = r_done;
  assign o_err_unexp      = r_err_unexp;
  assign o_err_timeout    = r_err_to;
  assign o_first_fail_src = r_ff_src;
endmodule

// File: tb/tb_tl_traffic_gen.sv
// Bench for tl_traffic_gen: memory-backed TL-UL slave plus a transaction-level scoring model.
module tb_tl_traffic_gen;
  logic        i_clk = 1'b0, i_rst = 1'b1;
  logic        i_cmd_valid = 1'b0, i_enable = 1'b0, i_a_ready = 1'b0;
  logic [1:0]  i_cmd_type = '0;
  logic [31:0] i_cmd_addr = '0;
  logic [2:0]  i_cmd_size = '0;
  logic [63:0] i_cmd_data = '0;
  logic [7:0]  i_cmd_mask = '0;
  logic        i_d_valid = 1'b0, i_d_denied = 1'b0, i_d_corrupt = 1'b0;
  logic [2:0]  i_d_opcode = '0;
  logic [3:0]  i_d_source = '0;
  logic [63:0] i_d_data = '0;
  logic        o_cmd_ready, o_a_valid, o_d_ready, o_done, o_err_unexp, o_err_timeout;
  logic [2:0]  o_a_opcode, o_a_param, o_a_size, o_inflight;
  logic [3:0]  o_a_source, o_first_fail_src;
  logic [31:0] o_a_address;
  logic [7:0]  o_a_mask;
  logic [63:0] o_a_data;
  logic [15:0] o_pass_count, o_fail_count;

  tl_traffic_gen dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_type(i_cmd_type), .i_cmd_addr(i_cmd_addr), .i_cmd_size(i_cmd_size),
    .i_cmd_data(i_cmd_data), .i_cmd_mask(i_cmd_mask), .i_enable(i_enable),
    .o_a_valid(o_a_valid), .i_a_ready(i_a_ready), .o_a_opcode(o_a_opcode),
    .o_a_param(o_a_param), .o_a_size(o_a_size), .o_a_source(o_a_source),
    .o_a_address(o_a_address), .o_a_mask(o_a_mask), .o_a_data(o_a_data),
    .i_d_valid(i_d_valid), .o_d_ready(o_d_ready), .i_d_opcode(i_d_opcode),
    .i_d_source(i_d_source), .i_d_data(i_d_data), .i_d_denied(i_d_denied),
    .i_d_corrupt(i_d_corrupt), .o_pass_count(o_pass_count), .o_fail_count(o_fail_count),
    .o_inflight(o_inflight), .o_done(o_done), .o_err_unexp(o_err_unexp),
    .o_err_timeout(o_err_timeout), .o_first_fail_src(o_first_fail_src)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]  typ;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [63:0] data;
    logic [7:0]  mask;
  } cmd_t;

  int          n_tests = 0, n_fail = 0;
  cmd_t        push_q[$], expa_q[$];
  int          src_log[$];
  bit          pend[4], busy_snap[4];
  cmd_t        pcmd[4];
  logic [63:0] prd[4], smem[4], mem[4];
  int          e_pass, e_fail, ff_src;
  bit          e_unexp, ff_v, a_prev;
  logic [63:0] a_stab;
  int          rnd_left = 0;
  int          cv_pct, ar_pct, en_pct, d_pct, err_pct;
  bit          hold_d, force_denied, inj_v;
  int          inj_src;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] bexp(input logic [7:0] m);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = {8{m[b]}};
    return r;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] m);
    return (old & ~bexp(m)) | (d & bexp(m));
  endfunction

  function automatic int ix(input logic [31:0] a);
    return int'(a[4:3]);
  endfunction

  function automatic int npend();
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(pend[i]);
    return n;
  endfunction

  function automatic logic [2:0] exp_op(input logic [1:0] t);
    return (t == 2'd0) ? 3'd4 : (t == 2'd1) ? 3'd0 : 3'd1;
  endfunction

  // A write lands in memory with its effective byte mask (PUTFULL writes every byte)
  function automatic logic [63:0] apply(input logic [63:0] old, input cmd_t c);
    return (c.typ == 2'd1) ? c.data : merge(old, c.data, c.mask);
  endfunction

  function automatic cmd_t gen_cmd();
    cmd_t c;
    int   r = $urandom_range(99);
    c.typ  = (r < 40) ? 2'd0 : (r < 65) ? 2'd1 : (r < 95) ? 2'd2 : 2'd3;
    c.addr = 32'h1000 + ($urandom_range(3) << 3);
    c.size = 3'($urandom_range(3));
    c.data = {$urandom, $urandom};
    c.mask = 8'($urandom);
    if (c.typ == 2'd0 && $urandom_range(99) < 70) c.data = smem[ix(c.addr)];
    return c;
  endfunction

  task automatic push(input logic [1:0] t, input logic [31:0] a, input logic [63:0] d,
                      input logic [7:0] m);
    cmd_t c;
    c.typ = t; c.addr = a; c.size = 3'd3; c.data = d; c.mask = m;
    push_q.push_back(c);
  endtask

  task automatic dflt();
    cv_pct = 100; ar_pct = 100; en_pct = 100; d_pct = 100; err_pct = 0;
    hold_d = 0; force_denied = 0; inj_v = 0;
  endtask

  task automatic make_rsp(input int s);
    bit isg = pcmd[s].typ == 2'd0;
    i_d_opcode = isg ? 3'd1 : 3'd0;
    i_d_data   = isg ? prd[s] : {$urandom, $urandom};
    if ($urandom_range(99) < err_pct) i_d_opcode = 3'($urandom_range(7));
    if ($urandom_range(99) < err_pct) i_d_data ^= 64'(1) << $urandom_range(63);
    i_d_denied  = force_denied || ($urandom_range(99) < err_pct);
    i_d_corrupt = $urandom_range(99) < err_pct;
  endtask

  task automatic score();
    int s = int'(i_d_source);
    if (s < 4 && pend[s]) begin
      cmd_t c = pcmd[s];
      bit isg = c.typ == 2'd0;
      bit bad = i_d_denied || i_d_corrupt || (i_d_opcode != (isg ? 3'd1 : 3'd0)) ||
                (isg && (((i_d_data ^ c.data) & bexp(c.mask)) != 0));
      if (bad) begin
        e_fail++;
        if (!ff_v) begin ff_v = 1; ff_src = s; end
      end else e_pass++;
      pend[s] = 0;
    end else e_unexp = 1;
  endtask

  // One clock: check what the DUT shows now, drive the next inputs, and advance the model
  task automatic step();
    int   plist[$];
    int   lf;
    cmd_t c;
    chk("inflight", 64'(o_inflight), 64'(npend()));
    if (o_a_valid && !a_prev) begin
      lf = -1;
      for (int i = 3; i >= 0; i--) if (!busy_snap[i]) lf = i;
      if (expa_q.size() == 0) chk("a_spurious", 64'(1), 64'(0));
      else begin
        c = expa_q[0];
        chk("a_source", 64'(o_a_source), 64'(lf));
        chk("a_opcode", 64'(o_a_opcode), 64'(exp_op(c.typ)));
        chk("a_mask",   64'(o_a_mask), 64'((c.typ == 2'd1) ? 8'hFF : c.mask));
        chk("a_data",   o_a_data, (c.typ == 2'd0) ? 64'(0) : c.data);
        chk("a_addr",   64'(o_a_address), 64'(c.addr));
        chk("a_size",   64'(o_a_size), 64'(c.size));
        chk("a_param",  64'(o_a_param), 64'(0));
      end
      src_log.push_back(int'(o_a_source));
      a_stab = 64'({o_a_address, o_a_source});
    end else if (o_a_valid) chk("a_stable", 64'({o_a_address, o_a_source}), a_stab);
    a_prev = o_a_valid;
    for (int i = 0; i < 4; i++) busy_snap[i] = pend[i];

    if (rnd_left > 0 && push_q.size() == 0) begin push_q.push_back(gen_cmd()); rnd_left--; end
    i_cmd_valid = (push_q.size() > 0) && ($urandom_range(99) < cv_pct);
    if (push_q.size() > 0) begin
      i_cmd_type = push_q[0].typ; i_cmd_addr = push_q[0].addr; i_cmd_size = push_q[0].size;
      i_cmd_data = push_q[0].data; i_cmd_mask = push_q[0].mask;
    end
    i_a_ready = $urandom_range(99) < ar_pct;
    i_enable  = $urandom_range(99) < en_pct;
    i_d_valid = 0; i_d_source = '0; i_d_opcode = '0; i_d_data = '0;
    i_d_denied = 0; i_d_corrupt = 0;
    for (int i = 0; i < 4; i++) if (pend[i]) plist.push_back(i);
    if (inj_v) begin
      i_d_valid = 1; i_d_source = 4'(inj_src); inj_v = 0;
    end else if (!hold_d && plist.size() > 0 && $urandom_range(99) < d_pct) begin
      i_d_valid = 1; i_d_source = 4'(plist[$urandom_range(plist.size()-1)]);
    end
    if (i_d_valid && int'(i_d_source) < 4 && pend[int'(i_d_source)]) make_rsp(int'(i_d_source));

    if (i_cmd_valid && o_cmd_ready) begin
      c = push_q.pop_front();
      if (c.typ == 2'd3) e_fail++;
      else begin
        expa_q.push_back(c);
        if (c.typ != 2'd0) smem[ix(c.addr)] = apply(smem[ix(c.addr)], c);
      end
    end
    if (i_d_valid) score();
    if (o_a_valid && i_a_ready && expa_q.size() > 0) begin
      c = expa_q.pop_front();
      pend[int'(o_a_source) % 4] = 1;
      pcmd[int'(o_a_source) % 4] = c;
      if (c.typ == 2'd0) prd[int'(o_a_source) % 4] = mem[ix(c.addr)];
      else               mem[ix(c.addr)] = apply(mem[ix(c.addr)], c);
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int q = 0, n = 0;
    while (q < 3 && n < budget) begin
      step();
      n++;
      if (push_q.size() == 0 && rnd_left == 0 && expa_q.size() == 0 && npend() == 0 && o_done)
        q++;
      else q = 0;
    end
    if (q < 3) chk({tag, "_quiet_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic do_reset();
    i_rst = 1; i_cmd_valid = 0; i_a_ready = 0; i_d_valid = 0; i_enable = 0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 0;
    push_q.delete(); expa_q.delete(); src_log.delete();
    for (int i = 0; i < 4; i++) begin
      pend[i] = 0; busy_snap[i] = 0; mem[i] = '0; smem[i] = '0;
    end
    e_pass = 0; e_fail = 0; e_unexp = 0; ff_v = 0; ff_src = 0; a_prev = 0; rnd_left = 0;
    dflt();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_a_valid"},   64'(o_a_valid), 64'(0));
    chk({tag, "_done"},      64'(o_done), 64'(1));
    chk({tag, "_cmd_ready"}, 64'(o_cmd_ready), 64'(1));
    chk({tag, "_d_ready"},   64'(o_d_ready), 64'(1));
    chk({tag, "_inflight"},  64'(o_inflight), 64'(0));
    chk({tag, "_pass"},      64'(o_pass_count), 64'(0));
    chk({tag, "_fail"},      64'(o_fail_count), 64'(0));
    chk({tag, "_err_unexp"}, 64'(o_err_unexp), 64'(0));
    chk({tag, "_err_to"},    64'(o_err_timeout), 64'(0));
    chk({tag, "_ffsrc"},     64'(o_first_fail_src), 64'(0));
  endtask

  initial begin
    int n;
    int f0;
    @(negedge i_clk);
    do_reset();
    chk_idle("rst");

    // T1: PUTFULL, mask forced to all ones
    push(2'd1, 32'h2000, 64'h11223344AABBCCDD, 8'h0F);
    wait_quiet("t1", 200);
    chk("t1_pass", 64'(o_pass_count), 64'(1));

    // T2: partial write then read-back compare
    push(2'd2, 32'h2000, 64'h00000000FFFFFFFF, 8'h0F);
    push(2'd0, 32'h2000, 64'h11223344FFFFFFFF, 8'hFF);
    wait_quiet("t2", 200);
    chk("t2_pass", 64'(o_pass_count), 64'(3));
    chk("t2_fail", 64'(o_fail_count), 64'(0));

    // enable low holds issue
    en_pct = 0;
    push(2'd0, 32'h2000, 64'h11223344FFFFFFFF, 8'hFF);
    repeat (8) step();
    chk("hold_a_valid", 64'(o_a_valid), 64'(0));
    chk("hold_done", 64'(o_done), 64'(0));
    en_pct = 100;
    wait_quiet("hold", 200);
    chk("hold_pass", 64'(o_pass_count), 64'(4));

    // T3: slots fill to MAX_INFLIGHT; freed source 2 is reused
    hold_d = 1;
    src_log.delete();
    repeat (5) push(2'd0, 32'h1000, smem[0], 8'hFF);
    repeat (20) step();
    chk("t3_inflight", 64'(o_inflight), 64'(4));
    chk("t3_a_stall", 64'(o_a_valid), 64'(0));
    chk("t3_nbeats", 64'(src_log.size()), 64'(4));
    for (int i = 0; i < 4 && i < src_log.size(); i++) chk("t3_src", 64'(src_log[i]), 64'(i));
    inj_v = 1; inj_src = 2;
    step();
    src_log.delete();
    n = 0;
    while (src_log.size() == 0 && n < 20) begin step(); n++; end
    chk("t3_reuse_seen", 64'(src_log.size()), 64'(1));
    if (src_log.size() > 0) chk("t3_reuse_src", 64'(src_log[0]), 64'(2));
    hold_d = 0;
    wait_quiet("t3", 300);
    chk("t3_pass", 64'(o_pass_count), 64'(9));

    // T4: byte-0 mismatch fails under FF mask, passes under FE
    push(2'd0, 32'h1000, smem[0] ^ 64'h1, 8'hFF);
    wait_quiet("t4a", 200);
    chk("t4_fail", 64'(o_fail_count), 64'(1));
    chk("t4_ffsrc", 64'(o_first_fail_src), 64'(0));
    push(2'd0, 32'h1000, smem[0] ^ 64'h1, 8'hFE);
    wait_quiet("t4b", 200);
    chk("t4_pass", 64'(o_pass_count), 64'(10));
    chk("t4_fail2", 64'(o_fail_count), 64'(1));

    // randomized traffic against the model
    cv_pct = 80; ar_pct = 60; en_pct = 90; d_pct = 40; err_pct = 12;
    rnd_left = 300;
    wait_quiet("rnd", 20000);
    dflt();
    chk("rnd_pass", 64'(o_pass_count), 64'(e_pass));
    chk("rnd_fail", 64'(o_fail_count), 64'(e_fail));
    if (ff_v) chk("rnd_ffsrc", 64'(o_first_fail_src), 64'(ff_src));
    chk("rnd_err_unexp", 64'(o_err_unexp), 64'(0));
    chk("rnd_err_to", 64'(o_err_timeout), 64'(0));

    // T5: unexpected D, then a denied GET
    inj_v = 1; inj_src = 3;
    step();
    step();
    chk("t5_err_unexp", 64'(o_err_unexp), 64'(e_unexp));
    chk("t5_pass", 64'(o_pass_count), 64'(e_pass));
    chk("t5_fail", 64'(o_fail_count), 64'(e_fail));
    f0 = e_fail;
    force_denied = 1;
    push(2'd0, 32'h1000, smem[0], 8'hFF);
    wait_quiet("t5", 200);
    force_denied = 0;
    chk("t5_denied", 64'(o_fail_count), 64'(f0 + 1));

    // T6: watchdog, then reset while a beat is offered
    hold_d = 1;
    push(2'd0, 32'h1000, smem[0], 8'hFF);
    repeat (500) step();
    chk("t6_to_early", 64'(o_err_timeout), 64'(0));
    repeat (600) step();
    chk("t6_to", 64'(o_err_timeout), 64'(1));
    ar_pct = 0;
    push(2'd0, 32'h1008, smem[1], 8'hFF);
    n = 0;
    while (!o_a_valid && n < 20) begin step(); n++; end
    chk("t6_issue", 64'(o_a_valid), 64'(1));
    do_reset();
    chk_idle("t6_rst");
    inj_v = 1; inj_src = 0;
    step();
    step();
    chk("t6_late_d", 64'(o_err_unexp), 64'(1));
    chk("t6_late_cnt", 64'(o_fail_count), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
